// File: rtl/pla_cube_pkg.sv
// Shared types and helpers for the PLA cube matcher.
// The optional ESOP output mode is PLA_CUBE_XOR_OUT_EN; it only touches the top level.
package pla_cube_pkg;

  localparam int CUBE_W_DEF = 17;
  localparam int MAX_IN     = 64;
  localparam int MAX_CUBES  = 32;

  typedef struct packed {
    logic                  en;
    logic [CUBE_W_DEF-1:0] care;
    logic [CUBE_W_DEF-1:0] val;
  } cube_t;

  function automatic int idx_width(input int nCubes);
    return (nCubes > 2) ? $clog2(nCubes) : 1;
  endfunction

  // Operands are zero-extended to MAX_IN so any N_IN can share one helper.
  function automatic logic cube_hit(input logic en,
                                    input logic [MAX_IN-1:0] care,
                                    input logic [MAX_IN-1:0] val,
                                    input logic [MAX_IN-1:0] vec);
    return en & (((vec ^ val) & care) == '0);
  endfunction

  function automatic int prio_enc(input logic [MAX_CUBES-1:0] hits);
    int idx;
    idx = 0;
    for (int i = MAX_CUBES - 1; i >= 0; i--) begin
      if (hits[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/pla_cube_table.sv
// Run-time programmable cube table with a one-write-per-two-cycles config handshake.
// Writes to indices at or beyond N_CUBES complete the handshake but change nothing.
module pla_cube_table
  import pla_cube_pkg::*;
#(
  parameter int N_IN    = 17,
  parameter int N_CUBES = 8,
  parameter int IDX_W   = idx_width(N_CUBES)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_valid_i,
  output logic                      cfg_ready_o,
  input  logic [IDX_W-1:0]          cfg_idx_i,
  input  logic [N_IN-1:0]           cfg_care_i,
  input  logic [N_IN-1:0]           cfg_val_i,
  input  logic                      cfg_en_i,
  output logic [N_CUBES-1:0]        tab_en_o,
  output logic [N_CUBES*N_IN-1:0]   tab_care_o,
  output logic [N_CUBES*N_IN-1:0]   tab_val_o
);

  logic [N_CUBES-1:0]           en_q;
  logic [N_CUBES-1:0][N_IN-1:0] care_q;
  logic [N_CUBES-1:0][N_IN-1:0] val_q;
  logic                         cfgReady_q;
  logic                         cfgAccept;

  assign cfgAccept = cfg_valid_i & cfgReady_q;

  // Ready is forced low for the cycle after every accepted write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q       <= '0;
      care_q     <= '0;
      val_q      <= '0;
      cfgReady_q <= 1'b1;
    end else begin
      cfgReady_q <= ~cfgAccept;
      for (int k = 0; k < N_CUBES; k++) begin
        if (cfgAccept && (int'(cfg_idx_i) == k)) begin
          en_q[k]   <= cfg_en_i;
          care_q[k] <= cfg_care_i;
          val_q[k]  <= cfg_val_i;
        end
      end
    end
  end

  assign cfg_ready_o = cfgReady_q;
  assign tab_en_o    = en_q;
  assign tab_care_o  = care_q;
  assign tab_val_o   = val_q;

endmodule

// File: rtl/pla_cube_matcher.sv
// Two-stage sum-of-products evaluator over a programmable cube table.
// Define PLA_CUBE_XOR_OUT_EN to add the xor_mode input (ESOP evaluation of y).
module pla_cube_matcher
  import pla_cube_pkg::*;
#(
  parameter int N_IN    = 17,
  parameter int N_CUBES = 8,
  parameter int CNT_W   = 16,
  localparam int IDX_W  = idx_width(N_CUBES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic [N_IN-1:0]    cfg_care,
  input  logic [N_IN-1:0]    cfg_val,
  input  logic               cfg_en,
  input  logic               in_valid,
  input  logic [N_IN-1:0]    in_vec,
`ifdef PLA_CUBE_XOR_OUT_EN
  input  logic               xor_mode,
`endif
  input  logic               cnt_clr,
  output logic               out_valid,
  output logic               y,
  output logic [N_CUBES-1:0] hit_vec,
  output logic [IDX_W-1:0]   first_hit,
  output logic [CNT_W-1:0]   hit_cnt
);

  logic [N_CUBES-1:0]      tabEn;
  logic [N_CUBES*N_IN-1:0] tabCare;
  logic [N_CUBES*N_IN-1:0] tabVal;

  pla_cube_table #(
    .N_IN    (N_IN),
    .N_CUBES (N_CUBES),
    .IDX_W   (IDX_W)
  ) u_table (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid_i (cfg_valid),
    .cfg_ready_o (cfg_ready),
    .cfg_idx_i   (cfg_idx),
    .cfg_care_i  (cfg_care),
    .cfg_val_i   (cfg_val),
    .cfg_en_i    (cfg_en),
    .tab_en_o    (tabEn),
    .tab_care_o  (tabCare),
    .tab_val_o   (tabVal)
  );

  logic              s1Valid_q;
  logic [N_IN-1:0]   s1Vec_q;
  logic              s1Xor_q;
  logic              s1Xor_d;

`ifdef PLA_CUBE_XOR_OUT_EN
  assign s1Xor_d = xor_mode;
`else
  assign s1Xor_d = 1'b0;
`endif

  logic [N_CUBES-1:0]   hit_d;
  logic                 y_d;
  logic [IDX_W-1:0]     firstHit_d;
  logic [MAX_IN-1:0]    vecW;
  logic [MAX_IN-1:0]    careW;
  logic [MAX_IN-1:0]    valW;
  logic [MAX_CUBES-1:0] hitW;

  // S2 evaluates against the table as it stands this cycle, so a write landing
  // on the same edge is only seen by later evaluations.
  always_comb begin
    vecW             = '0;
    vecW[N_IN-1:0]   = s1Vec_q;
    careW            = '0;
    valW             = '0;
    hit_d            = '0;
    for (int k = 0; k < N_CUBES; k++) begin
      careW           = '0;
      valW            = '0;
      careW[N_IN-1:0] = tabCare[k*N_IN +: N_IN];
      valW[N_IN-1:0]  = tabVal[k*N_IN +: N_IN];
      hit_d[k]        = cube_hit(tabEn[k], careW, valW, vecW);
    end
    hitW                = '0;
    hitW[N_CUBES-1:0]   = hit_d;
    y_d                 = s1Xor_q ? ^hit_d : |hit_d;
    firstHit_d          = y_d ? IDX_W'(prio_enc(hitW)) : '0;
  end

  logic               outValid_q;
  logic               y_q;
  logic [N_CUBES-1:0] hitVec_q;
  logic [IDX_W-1:0]   firstHit_q;
  logic [CNT_W-1:0]   hitCnt_q;

  // Result registers hold between valid results; the counter saturates and
  // cnt_clr wins over a simultaneous increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1Valid_q  <= 1'b0;
      s1Vec_q    <= '0;
      s1Xor_q    <= 1'b0;
      outValid_q <= 1'b0;
      y_q        <= 1'b0;
      hitVec_q   <= '0;
      firstHit_q <= '0;
      hitCnt_q   <= '0;
    end else begin
      s1Valid_q  <= in_valid;
      if (in_valid) begin
        s1Vec_q <= in_vec;
        s1Xor_q <= s1Xor_d;
      end
      outValid_q <= s1Valid_q;
      if (s1Valid_q) begin
        y_q        <= y_d;
        hitVec_q   <= hit_d;
        firstHit_q <= firstHit_d;
      end
      if (cnt_clr) begin
        hitCnt_q <= '0;
      end else if (s1Valid_q && y_d && (hitCnt_q != '1)) begin
        hitCnt_q <= hitCnt_q + 1'b1;
      end
    end
  end

  assign out_valid = outValid_q;
  assign y         = y_q;
  assign hit_vec   = hitVec_q;
  assign first_hit = firstHit_q;
  assign hit_cnt   = hitCnt_q;

endmodule

// File: tb/tb_pla_cube_matcher.sv
// Bench for pla_cube_matcher: an 8-cube/16-bit-count instance and a 6-cube/4-bit-count
// instance share all inputs; a cycle-level reference model checks both every cycle.
module tb_pla_cube_matcher;

  localparam int NA = 8;
  localparam int NB = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfgValid;
  logic [2:0]  cfgIdx;
  logic [16:0] cfgCare;
  logic [16:0] cfgVal;
  logic        cfgEn;
  logic        inValid;
  logic [16:0] inVec;
  logic        cntClr;
  logic        xorMode;

  logic        cfgReadyA, outValidA, yA;
  logic [7:0]  hitVecA;
  logic [2:0]  firstHitA;
  logic [15:0] hitCntA;
  logic        cfgReadyB, outValidB, yB;
  logic [5:0]  hitVecB;
  logic [2:0]  firstHitB;
  logic [3:0]  hitCntB;

  always #5 clk = ~clk;

  pla_cube_matcher #(.N_IN(17), .N_CUBES(NA), .CNT_W(16)) dutA (
    .clk(clk), .rst(rst), .cfg_valid(cfgValid), .cfg_ready(cfgReadyA),
    .cfg_idx(cfgIdx), .cfg_care(cfgCare), .cfg_val(cfgVal), .cfg_en(cfgEn),
    .in_valid(inValid), .in_vec(inVec),
`ifdef PLA_CUBE_XOR_OUT_EN
    .xor_mode(xorMode),
`endif
    .cnt_clr(cntClr), .out_valid(outValidA), .y(yA), .hit_vec(hitVecA),
    .first_hit(firstHitA), .hit_cnt(hitCntA)
  );

  pla_cube_matcher #(.N_IN(17), .N_CUBES(NB), .CNT_W(4)) dutB (
    .clk(clk), .rst(rst), .cfg_valid(cfgValid), .cfg_ready(cfgReadyB),
    .cfg_idx(cfgIdx), .cfg_care(cfgCare), .cfg_val(cfgVal), .cfg_en(cfgEn),
    .in_valid(inValid), .in_vec(inVec),
`ifdef PLA_CUBE_XOR_OUT_EN
    .xor_mode(xorMode),
`endif
    .cnt_clr(cntClr), .out_valid(outValidB), .y(yB), .hit_vec(hitVecB),
    .first_hit(firstHitB), .hit_cnt(hitCntB)
  );

  // Reference model: cube table as plain arrays plus expected visible outputs.
  typedef struct {
    bit         ov;
    bit         y;
    logic [7:0] hv;
    int         fh;
    int         cnt;
  } exp_t;

  bit          mEn   [NA];
  logic [16:0] mCare [NA];
  logic [16:0] mVal  [NA];
  bit          mReady;
  bit          pendValid;
  logic [16:0] pendVec;
  bit          pendXor;
  exp_t        eA, eB;
  logic [7:0]  mH;
  bit          mAcc;

  function automatic logic [7:0] modelHits(logic [16:0] v);
    logic [7:0] h;
    h = '0;
    for (int k = 0; k < NA; k++)
      h[k] = mEn[k] && (((v ^ mVal[k]) & mCare[k]) == 17'd0);
    return h;
  endfunction

  function automatic bit yOf(logic [7:0] h, int n, bit x);
    int c;
    c = 0;
    for (int i = 0; i < n; i++) c += int'(h[i]);
    return x ? (c % 2 == 1) : (c != 0);
  endfunction

  function automatic int firstOf(logic [7:0] h, int n);
    for (int i = 0; i < n; i++) if (h[i]) return i;
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NA; k++) begin
        mEn[k] = 1'b0; mCare[k] = '0; mVal[k] = '0;
      end
      mReady = 1'b1; pendValid = 1'b0; pendVec = '0; pendXor = 1'b0;
      eA = '{1'b0, 1'b0, 8'h00, 0, 0};
      eB = '{1'b0, 1'b0, 8'h00, 0, 0};
    end else begin
      mH   = modelHits(pendVec);
      eA.ov = pendValid;
      eB.ov = pendValid;
      if (pendValid) begin
        eA.hv = mH;
        eA.y  = yOf(mH, NA, pendXor);
        eA.fh = eA.y ? firstOf(mH, NA) : 0;
        eB.hv = mH & 8'h3F;
        eB.y  = yOf(mH, NB, pendXor);
        eB.fh = eB.y ? firstOf(mH, NB) : 0;
      end
      if (cntClr) begin
        eA.cnt = 0; eB.cnt = 0;
      end else if (pendValid) begin
        if (eA.y && eA.cnt < 65535) eA.cnt++;
        if (eB.y && eB.cnt < 15) eB.cnt++;
      end
      mAcc = cfgValid && mReady;
      if (mAcc) begin
        mEn[cfgIdx] = cfgEn; mCare[cfgIdx] = cfgCare; mVal[cfgIdx] = cfgVal;
      end
      mReady    = !mAcc;
      pendValid = inValid;
      pendVec   = inVec;
      pendXor   = xorMode;
    end
  end

  int nVec = 0;
  int nMis = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    chk("ovA", 64'(outValidA), 64'(eA.ov));
    chk("yA", 64'(yA), 64'(eA.y));
    chk("hitA", 64'(hitVecA), 64'(eA.hv));
    chk("firstA", 64'(firstHitA), 64'(eA.fh));
    chk("cntA", 64'(hitCntA), 64'(eA.cnt));
    chk("rdyA", 64'(cfgReadyA), 64'(mReady));
    chk("ovB", 64'(outValidB), 64'(eB.ov));
    chk("yB", 64'(yB), 64'(eB.y));
    chk("hitB", 64'(hitVecB), 64'(eB.hv));
    chk("firstB", 64'(firstHitB), 64'(eB.fh));
    chk("cntB", 64'(hitCntB), 64'(eB.cnt));
    chk("rdyB", 64'(cfgReadyB), 64'(mReady));
  endtask

  task automatic applyStimulus(bit cv, logic [2:0] ci, logic [16:0] cc, logic [16:0] cvl,
                               bit ce, bit iv, logic [16:0] vec, bit clr, bit xm);
    cfgValid = cv; cfgIdx = ci; cfgCare = cc; cfgVal = cvl; cfgEn = ce;
    inValid = iv; inVec = vec; cntClr = clr; xorMode = xm;
    @(negedge clk);
    checkOutput();
  endtask

  task automatic idle();
    applyStimulus(1'b0, 3'd0, 17'd0, 17'd0, 1'b0, 1'b0, 17'd0, 1'b0, 1'b0);
  endtask

  typedef struct {
    bit          isWrite;
    logic [2:0]  idx;
    logic [16:0] care;
    logic [16:0] val;
    bit          en;
    logic [16:0] vec;
    bit          expY;
    logic [7:0]  expHit;
    logic [2:0]  expFirst;
  } dirVec_t;

  dirVec_t     dirTab [11];
  logic [16:0] rCare, rVal, rVec;
  int          rK;

  initial begin
    dirTab[0]  = '{1'b1, 3'd0, 17'h1FFFF, 17'h1FA59, 1'b1, 17'h00000, 1'b0, 8'h00, 3'd0};
    dirTab[1]  = '{1'b0, 3'd0, 17'h00000, 17'h00000, 1'b0, 17'h1FA59, 1'b1, 8'h01, 3'd0};
    dirTab[2]  = '{1'b0, 3'd0, 17'h00000, 17'h00000, 1'b0, 17'h1FA58, 1'b0, 8'h00, 3'd0};
    dirTab[3]  = '{1'b1, 3'd3, 17'h00003, 17'h00001, 1'b1, 17'h00000, 1'b0, 8'h00, 3'd0};
    dirTab[4]  = '{1'b1, 3'd5, 17'h00000, 17'h00000, 1'b1, 17'h00000, 1'b0, 8'h00, 3'd0};
    dirTab[5]  = '{1'b0, 3'd0, 17'h00000, 17'h00000, 1'b0, 17'h00001, 1'b1, 8'h28, 3'd3};
    dirTab[6]  = '{1'b1, 3'd3, 17'h00003, 17'h00001, 1'b0, 17'h00000, 1'b0, 8'h00, 3'd0};
    dirTab[7]  = '{1'b0, 3'd0, 17'h00000, 17'h00000, 1'b0, 17'h00001, 1'b1, 8'h20, 3'd5};
    dirTab[8]  = '{1'b0, 3'd0, 17'h00000, 17'h00000, 1'b0, 17'h1FA59, 1'b1, 8'h21, 3'd0};
    dirTab[9]  = '{1'b1, 3'd7, 17'h1FFFF, 17'h00000, 1'b1, 17'h00000, 1'b0, 8'h00, 3'd0};
    dirTab[10] = '{1'b0, 3'd0, 17'h00000, 17'h00000, 1'b0, 17'h00000, 1'b1, 8'hA0, 3'd5};

    cfgValid = 0; cfgIdx = 0; cfgCare = 0; cfgVal = 0; cfgEn = 0;
    inValid = 0; inVec = 0; cntClr = 0; xorMode = 0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1 checkOutput();
    @(negedge clk);
    checkOutput();
    rst = 1'b0;
    idle();

    // Directed table: writes then single evaluations with known answers.
    for (int i = 0; i < 11; i++) begin
      if (dirTab[i].isWrite) begin
        applyStimulus(1'b1, dirTab[i].idx, dirTab[i].care, dirTab[i].val, dirTab[i].en,
                      1'b0, 17'd0, 1'b0, 1'b0);
        idle();
      end else begin
        applyStimulus(1'b0, 3'd0, 17'd0, 17'd0, 1'b0, 1'b1, dirTab[i].vec, 1'b0, 1'b0);
        idle();
        chk($sformatf("dirOv%0d", i), 64'(outValidA), 64'd1);
        chk($sformatf("dirY%0d", i), 64'(yA), 64'(dirTab[i].expY));
        chk($sformatf("dirHit%0d", i), 64'(hitVecA), 64'(dirTab[i].expHit));
        chk($sformatf("dirFirst%0d", i), 64'(firstHitA), 64'(dirTab[i].expFirst));
        chk($sformatf("dirHitB%0d", i), 64'(hitVecB), 64'(dirTab[i].expHit & 8'h3F));
        if (i == 1) chk("dirCnt1", 64'(hitCntA), 64'd1);
        idle();
      end
    end

    // Handshake: ready low exactly one cycle after an accepted write.
    applyStimulus(1'b1, 3'd6, 17'h1FFFF, 17'h1FFFF, 1'b1, 1'b0, 17'd0, 1'b0, 1'b0);
    chk("rdyLow", 64'(cfgReadyA), 64'd0);
    applyStimulus(1'b1, 3'd6, 17'h1FFFF, 17'h1FFFF, 1'b1, 1'b0, 17'd0, 1'b0, 1'b0);
    chk("rdyHigh", 64'(cfgReadyA), 64'd1);
    idle();

    // Saturation of the 4-bit counter; cube 5 always hits.
    for (int i = 0; i < 20; i++)
      applyStimulus(1'b0, 3'd0, 17'd0, 17'd0, 1'b0, 1'b1, 17'($urandom), 1'b0, 1'b0);
    idle(); idle();
    chk("satB", 64'(hitCntB), 64'd15);
    applyStimulus(1'b0, 3'd0, 17'd0, 17'd0, 1'b0, 1'b1, 17'h00001, 1'b0, 1'b0);
    applyStimulus(1'b0, 3'd0, 17'd0, 17'd0, 1'b0, 1'b0, 17'd0, 1'b1, 1'b0);
    chk("clrOv", 64'(outValidA), 64'd1);
    chk("clrCntA", 64'(hitCntA), 64'd0);
    chk("clrCntB", 64'(hitCntB), 64'd0);
    idle();

    // Asynchronous reset with two inputs in flight.
    applyStimulus(1'b0, 3'd0, 17'd0, 17'd0, 1'b0, 1'b1, 17'h1FA59, 1'b0, 1'b0);
    inValid = 1'b1; inVec = 17'h00001;
    @(posedge clk);
    #2 rst = 1'b1;
    #1 checkOutput();
    chk("rstOv", 64'(outValidA), 64'd0);
    chk("rstHit", 64'(hitVecA), 64'd0);
    chk("rstCnt", 64'(hitCntA), 64'd0);
    inValid = 1'b0;
    @(negedge clk);
    checkOutput();
    rst = 1'b0;
    idle(); idle();
    applyStimulus(1'b0, 3'd0, 17'd0, 17'd0, 1'b0, 1'b1, 17'h1FA59, 1'b0, 1'b0);
    idle();
    chk("postRstOv", 64'(outValidA), 64'd1);
    chk("postRstY", 64'(yA), 64'd0);
    idle();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rCare = 17'($urandom) & 17'($urandom) & 17'($urandom);
      rVal  = 17'($urandom);
      rK    = $urandom_range(0, NA - 1);
      rVec  = ($urandom_range(0, 1) == 1) ?
              ((mVal[rK] & mCare[rK]) | (17'($urandom) & ~mCare[rK])) : 17'($urandom);
      applyStimulus($urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)), rCare, rVal,
                    $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7, rVec,
                    $urandom_range(0, 29) == 0,
`ifdef PLA_CUBE_XOR_OUT_EN
                    1'($urandom_range(0, 1))
`else
                    1'b0
`endif
                    );
    end
    idle(); idle();

`ifdef PLA_CUBE_XOR_OUT_EN
    rst = 1'b1;
    idle();
    rst = 1'b0;
    applyStimulus(1'b1, 3'd0, 17'd0, 17'd0, 1'b1, 1'b0, 17'd0, 1'b0, 1'b0);
    idle();
    applyStimulus(1'b1, 3'd1, 17'd0, 17'd0, 1'b1, 1'b0, 17'd0, 1'b0, 1'b0);
    idle();
    applyStimulus(1'b0, 3'd0, 17'd0, 17'd0, 1'b0, 1'b1, 17'h0ABCD, 1'b0, 1'b1);
    idle();
    chk("xorY", 64'(yA), 64'd0);
    applyStimulus(1'b0, 3'd0, 17'd0, 17'd0, 1'b0, 1'b1, 17'h0ABCD, 1'b0, 1'b0);
    idle();
    chk("orY", 64'(yA), 64'd1);
    idle();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
